// File: rtl/sobel_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_buffer_if
// Description : Pixel-stream and 3x3 window bus for sobel_window_buffer.
//               Optional frame_start input under SOBEL_WIN_FRAME_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_window_buffer_if;
    logic       pixel_valid;
    logic [7:0] pixel_in;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
    logic       frame_start;
`endif
    logic [7:0] P0;
    logic [7:0] P1;
    logic [7:0] P2;
    logic [7:0] P3;
    logic [7:0] P4;
    logic [7:0] P5;
    logic [7:0] P6;
    logic [7:0] P7;
    logic [7:0] P8;
    logic       start_calculations;
    logic       frame_done;

`ifdef SOBEL_WIN_FRAME_SYNC_EN
    modport master (
        output pixel_valid, pixel_in, frame_start,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8,
        input  start_calculations, frame_done
    );
    modport slave (
        input  pixel_valid, pixel_in, frame_start,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8,
        output start_calculations, frame_done
    );
`else
    modport master (
        output pixel_valid, pixel_in,
        input  P0, P1, P2, P3, P4, P5, P6, P7, P8,
        input  start_calculations, frame_done
    );
    modport slave (
        input  pixel_valid, pixel_in,
        output P0, P1, P2, P3, P4, P5, P6, P7, P8,
        output start_calculations, frame_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_buffer
// Description : Streaming 3x3 neighbourhood generator with two line buffers.
//               Macro SOBEL_WIN_FRAME_SYNC_EN adds frame_start resync.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sobel_window_buffer_if.slave  bus
);

    localparam int c_col_w = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int c_row_w = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [c_col_w-1:0] w_col_pos;
    logic [c_row_w-1:0] w_row_pos;
    logic [c_col_w-1:0] w_col_nxt;
    logic [c_row_w-1:0] w_row_nxt;

    logic [7:0]         r_lb_top [IMG_WIDTH];
    logic [7:0]         r_lb_mid [IMG_WIDTH];
    logic [7:0]         w_top;
    logic [7:0]         w_mid;

    logic [7:0]         r_win [9];
    logic               r_start;
    logic               r_done;

    logic               w_accept;
    logic               w_fs;
    logic               w_in_window;
    logic               w_last_pixel;

    assign w_accept = bus.pixel_valid;

`ifdef SOBEL_WIN_FRAME_SYNC_EN
    assign w_fs = bus.frame_start;
`else
    assign w_fs = 1'b0;
`endif

    // A frame_start pixel is treated as position (0,0) for every decision made on it.
    assign w_col_pos    = w_fs ? '0 : r_col;
    assign w_row_pos    = w_fs ? '0 : r_row;

    assign w_in_window  = (w_row_pos >= c_row_two) && (w_col_pos >= c_col_two);
    assign w_last_pixel = (w_row_pos == c_row_last) && (w_col_pos == c_col_last);

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_accept) begin
            if (w_col_pos == c_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = (w_row_pos == c_row_last) ? '0 : (w_row_pos + c_row_w'(1));
            end else begin
                w_col_nxt = w_col_pos + c_col_w'(1);
                w_row_nxt = w_row_pos;
            end
        end else if (w_fs) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Register-based line buffers: the combinational reads below see the
    // pre-edge contents, giving read-before-write at the shared address.
    assign w_top = r_lb_top[w_col_pos];
    assign w_mid = r_lb_mid[w_col_pos];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb_top[w_col_pos] <= r_lb_mid[w_col_pos];
            r_lb_mid[w_col_pos] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= w_accept && w_in_window;
            r_done  <= w_accept && w_last_pixel;
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= bus.pixel_in;
            end
        end
    end

    assign bus.P0                 = r_win[0];
    assign bus.P1                 = r_win[1];
    assign bus.P2                 = r_win[2];
    assign bus.P3                 = r_win[3];
    assign bus.P4                 = r_win[4];
    assign bus.P5                 = r_win[5];
    assign bus.P6                 = r_win[6];
    assign bus.P7                 = r_win[7];
    assign bus.P8                 = r_win[8];
    assign bus.start_calculations = r_start;
    assign bus.frame_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_buffer
// Description : Scoreboard bench for sobel_window_buffer (4x4 image).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    sobel_window_buffer_if bus();

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            strobe;
        logic            fd;
        logic            known;
        logic [8:0][7:0] w;
    } exp_t;

    exp_t            q[$];
    int              n_cmp  = 0;
    int              n_fail = 0;

    // Reference model: the image as a 2D array, position in raster order.
    int              mr, mc;
    logic [7:0]      img [H][W];
    logic [8:0][7:0] last_win;
    logic            known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0][7:0] dut_win();
        return {bus.P8, bus.P7, bus.P6, bus.P5, bus.P4, bus.P3, bus.P2, bus.P1, bus.P0};
    endfunction

    task automatic model_reset();
        mr       = 0;
        mc       = 0;
        known    = 1'b1;
        last_win = '0;
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic fs);
        exp_t e;
        bus.pixel_valid = v;
        bus.pixel_in    = p;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
        bus.frame_start = fs;
`endif
        @(posedge clk);
        e = '0;
        if (v) begin
            if (fs) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        last_win[rr*3+cc] = img[mr-2+rr][mc-2+cc];
                known    = 1'b1;
                e.strobe = 1'b1;
            end else begin
                known = 1'b0;
            end
            e.fd = (mr == H-1) && (mc == W-1);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end else if (fs) begin
            mr = 0;
            mc = 0;
        end
        e.known = known;
        e.w     = last_win;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pattern_frame(input logic invert, input int gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                logic [7:0] p;
                p = 8'(16*r + c);
                if (invert) p = 8'hFF - p;
                step(1'b1, p, 1'b0);
                for (int g = 0; g < gaps; g++) step(1'b0, 8'h00, 1'b0);
            end
    endtask

    // Monitor: one expectation per clock edge, compared on the falling edge.
    initial begin : monitor
        exp_t            e;
        logic [8:0][7:0] a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("start_calculations", 32'(bus.start_calculations), 32'(e.strobe));
                check("frame_done", 32'(bus.frame_done), 32'(e.fd));
                if (e.known) begin
                    a = dut_win();
                    for (int k = 0; k < 9; k++)
                        check($sformatf("P%0d", k), 32'(a[k]), 32'(e.w[k]));
                end
            end else begin
                check("idle_strobe", 32'(bus.start_calculations), 32'd0);
                check("idle_frame_done", 32'(bus.frame_done), 32'd0);
            end
        end
    end

    initial begin : stimulus
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = 8'h00;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
        bus.frame_start = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        step(1'b0, 8'h00, 1'b0);
        pattern_frame(1'b0, 0);
        pattern_frame(1'b0, 2);
        pattern_frame(1'b1, 0);

        // Mid-frame asynchronous reset right after the (2,2) strobe.
        for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0);
        #2 n_rst = 1'b0;
        #1;
        check("rst_win", 32'(dut_win() != '0), 32'd0);
        check("rst_strobe", 32'(bus.start_calculations), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        bus.pixel_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        pattern_frame(1'b0, 1);

`ifdef SOBEL_WIN_FRAME_SYNC_EN
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b0);
`endif

        for (int i = 0; i < 6*W*H*2; i++) begin
            logic fs;
            fs = 1'b0;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
            fs = ($urandom_range(0, 24) == 0);
`endif
            step($urandom_range(0, 2) != 0, 8'($urandom), fs);
        end

        step(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
